// File: rtl/mmss_counter_pkg.sv
// mmss_pkg: shared types and constants for the minute/second time base.
// Holds the control FSM state encoding, the field widths and limits of the
// packed {minute, second} word, the count-direction encodings and a small
// helper that clamps a preset field into the legal 0..59 range.
package mmss_pkg;

   // Control FSM states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      DONE   = 2'd3
   } state_e;

   // Field widths of the packed output word
   localparam int MIN_W = 6;
   localparam int SEC_W = 6;
   localparam int OUT_W = MIN_W + SEC_W;

   // Largest legal value of each field
   localparam logic [MIN_W-1:0] MAX_MIN = 6'd59;
   localparam logic [SEC_W-1:0] MAX_SEC = 6'd59;

   // Count direction, as sampled from the mode input
   localparam logic MODE_UP   = 1'b0;
   localparam logic MODE_DOWN = 1'b1;

   // Presets above 59 saturate at 59 rather than wrapping
   function automatic logic [5:0] clamp59(input logic [5:0] v);
      return (v > 6'd59) ? 6'd59 : v;
   endfunction

endpackage

// File: rtl/mmss_counter_tick_prescaler.sv
// tick_prescaler: divides clk down to the count-advance rate.
// The counter runs 0..DIV-1 while en_i is high, holds while en_i is low and
// is forced to zero by zero_i (which beats en_i). tick_o is high for the one
// cycle in which the counter sits at its terminal value DIV-1 while enabled,
// so consecutive ticks are exactly DIV enabled cycles apart.
module tick_prescaler #(
   parameter int DIV = 12_000_000
) (
   input  logic clk,
   input  logic nrst,
   input  logic en_i,
   input  logic zero_i,
   output logic tick_o
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] TC = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             at_tc;

   assign at_tc = (cnt_q == TC);

   // Next count: zero wins, otherwise advance and wrap while enabled
   always_comb begin
      cnt_d = cnt_q;
      if (zero_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = at_tc ? '0 : cnt_q + 1'b1;
      end
   end

   // Divider register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A zeroing cycle never produces a tick, so no advance is lost or doubled
   assign tick_o = en_i & ~zero_i & at_tc;

endmodule

// File: rtl/mmss_counter.sv
// mmss_counter: minute/second stopwatch / countdown time base.
// Produces the packed {minute, second} binary word for the display decoder.
// Controls (clear > load > stop > start) drive a four-state FSM; the count
// advances once per prescaler tick while running and done pulses once on the
// terminal count (59:59 counting up, 00:00 counting down).
// Optional build macro MMSS_COUNTER_LAP_EN adds a lap-hold register that
// freezes counter_out while the internal count keeps running; without it
// the lap input is ignored.
module mmss_counter
   import mmss_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 12_000_000,
   parameter int TICK_HZ     = 1
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             start,
   input  logic             stop,
   input  logic             clear,
   input  logic             load,
   input  logic             mode,
   input  logic [MIN_W-1:0] load_min,
   input  logic [SEC_W-1:0] load_sec,
   input  logic             lap,
   output logic [OUT_W-1:0] counter_out,
   output logic             running,
   output logic             tick,
   output logic             done
);

   localparam int DIV = CLK_FREQ_HZ / TICK_HZ;

   state_e           state_q, state_d;
   logic [MIN_W-1:0] min_q, min_d;
   logic [SEC_W-1:0] sec_q, sec_d;
   logic             mode_q, mode_d;
   logic             done_q, done_d;

   logic             presc_en;
   logic             presc_zero;
   logic             tick_w;
   logic             start_eff;
   logic [MIN_W-1:0] adv_min;
   logic [SEC_W-1:0] adv_sec;
   logic             adv_term;
   logic [OUT_W-1:0] live_count;

   // The divider only runs in RUN; it is zeroed on clear, load and on a
   // fresh start from IDLE, so a resume from PAUSED keeps its partial count.
   assign presc_en = (state_q == RUN);

   tick_prescaler #(
      .DIV (DIV)
   ) u_prescaler (
      .clk    (clk),
      .nrst   (nrst),
      .en_i   (presc_en),
      .zero_i (presc_zero),
      .tick_o (tick_w)
   );

   // stop outranks start, so a simultaneous start is dropped
   assign start_eff = start & ~stop;

   // One-second advance in the latched direction, plus terminal detection
   always_comb begin
      adv_min = min_q;
      adv_sec = sec_q;
      if (mode_q == MODE_UP) begin
         if (sec_q == MAX_SEC) begin
            // 59:59 has nowhere to go; it holds and reads as terminal
            if (min_q != MAX_MIN) begin
               adv_sec = '0;
               adv_min = min_q + 1'b1;
            end
         end else begin
            adv_sec = sec_q + 1'b1;
         end
      end else begin
         if (sec_q == '0) begin
            if (min_q != '0) begin
               adv_sec = MAX_SEC;
               adv_min = min_q - 1'b1;
            end
         end else begin
            adv_sec = sec_q - 1'b1;
         end
      end
      if (mode_q == MODE_UP) begin
         adv_term = (adv_min == MAX_MIN) && (adv_sec == MAX_SEC);
      end else begin
         adv_term = (adv_min == '0) && (adv_sec == '0);
      end
   end

   // Control FSM next state, count update and prescaler zeroing
   always_comb begin
      state_d    = state_q;
      min_d      = min_q;
      sec_d      = sec_q;
      mode_d     = mode_q;
      done_d     = 1'b0;
      presc_zero = 1'b0;
      if (clear) begin
         min_d      = '0;
         sec_d      = '0;
         state_d    = IDLE;
         presc_zero = 1'b1;
      end else if (load) begin
         min_d      = clamp59(load_min);
         sec_d      = clamp59(load_sec);
         state_d    = IDLE;
         presc_zero = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_eff) begin
                  mode_d     = mode;
                  presc_zero = 1'b1;
                  // A countdown from 00:00 has nothing to count
                  if ((mode == MODE_DOWN) && (min_q == '0) && (sec_q == '0)) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = RUN;
                  end
               end
            end
            RUN: begin
               if (tick_w) begin
                  min_d = adv_min;
                  sec_d = adv_sec;
               end
               // Reaching the terminal count takes precedence over a pause
               if (tick_w && adv_term) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else if (stop) begin
                  state_d = PAUSED;
               end
            end
            PAUSED: begin
               if (start_eff) begin
                  state_d = RUN;
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State, count, latched direction and done pulse registers
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
         min_q   <= '0;
         sec_q   <= '0;
         mode_q  <= MODE_UP;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         min_q   <= min_d;
         sec_q   <= sec_d;
         mode_q  <= mode_d;
         done_q  <= done_d;
      end
   end

   assign live_count = {min_q, sec_q};

`ifdef MMSS_COUNTER_LAP_EN
   logic             lap_hold_q, lap_hold_d;
   logic [OUT_W-1:0] lap_val_q, lap_val_d;

   // Lap toggles a frozen snapshot while timing; clear/load release it
   always_comb begin
      lap_hold_d = lap_hold_q;
      lap_val_d  = lap_val_q;
      if (clear || load) begin
         lap_hold_d = 1'b0;
      end else if (lap && ((state_q == RUN) || (state_q == PAUSED))) begin
         if (lap_hold_q) begin
            lap_hold_d = 1'b0;
         end else begin
            lap_hold_d = 1'b1;
            lap_val_d  = live_count;
         end
      end
   end

   // Lap hold flag and snapshot registers
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         lap_hold_q <= 1'b0;
         lap_val_q  <= '0;
      end else begin
         lap_hold_q <= lap_hold_d;
         lap_val_q  <= lap_val_d;
      end
   end

   assign counter_out = lap_hold_q ? lap_val_q : live_count;
`else
   // Lap is accepted on the port but has no effect in this build
   logic lap_unused;
   assign lap_unused  = lap;
   assign counter_out = live_count;
`endif

   assign running = (state_q == RUN);
   assign tick    = tick_w;
   assign done    = done_q;

endmodule

// File: tb/tb_mmss_counter.sv
// tb_mmss_counter: directed self-checking bench for mmss_counter.
// Runs with a 4-cycle tick period (CLK_FREQ_HZ = 4, TICK_HZ = 1).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// Lap checks follow the MMSS_COUNTER_LAP_EN build option.
module tb_mmss_counter;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        clear = 1'b0;
   logic        load = 1'b0;
   logic        mode = 1'b0;
   logic        lap = 1'b0;
   logic [5:0]  load_min = 6'd0;
   logic [5:0]  load_sec = 6'd0;
   logic [11:0] counter_out;
   logic        running;
   logic        tick;
   logic        done;

   int n_cmp = 0;
   int n_err = 0;

   mmss_counter #(
      .CLK_FREQ_HZ (4),
      .TICK_HZ     (1)
   ) dut (
      .clk         (clk),
      .nrst        (nrst),
      .start       (start),
      .stop        (stop),
      .clear       (clear),
      .load        (load),
      .mode        (mode),
      .load_min    (load_min),
      .load_sec    (load_sec),
      .lap         (lap),
      .counter_out (counter_out),
      .running     (running),
      .tick        (tick),
      .done        (done)
   );

   always #5 clk = ~clk;

   // Every comparison goes through here
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] mmss(input int m, input int s);
      return {6'(m), 6'(s)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Steps until tick is seen; k = edges taken. Bounded.
   task automatic wait_tick(output int k);
      k = 0;
      do begin
         step();
         k++;
      end while ((tick !== 1'b1) && (k < 40));
      if (tick !== 1'b1) chk("tick_timeout", 32'd0, 32'd1);
   endtask

   // n full ticks, each followed by the edge that applies it
   task automatic run_ticks(input int n);
      int k;
      for (int i = 0; i < n; i++) begin
         wait_tick(k);
         step();
      end
   endtask

   task automatic pulse_start(input logic m);
      mode = m;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      step();
      stop = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   task automatic do_load(input logic [5:0] mm, input logic [5:0] ss);
      load_min = mm;
      load_sec = ss;
      load = 1'b1;
      step();
      load = 1'b0;
   endtask

   task automatic pulse_lap();
      lap = 1'b1;
      step();
      lap = 1'b0;
   endtask

   initial begin
      int k;
      int bad;
      int ndone;

      // ---- reset state ----
      step();
      chk("rst_count", 32'(counter_out), 32'd0);
      chk("rst_running", 32'(running), 32'd0);
      chk("rst_tick", 32'(tick), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      nrst = 1'b1;
      step();
      $display("phase: tick timing");

      // ---- tick timing: first tick 4 edges after start, then every 4 ----
      pulse_start(1'b0);
      chk("start_running", 32'(running), 32'd1);
      chk("start_count", 32'(counter_out), 32'(mmss(0, 0)));
      wait_tick(k);
      chk("first_tick_lat", 32'(k), 32'd3);
      step();
      chk("after_tick1", 32'(counter_out), 32'(mmss(0, 1)));
      chk("tick_low_after", 32'(tick), 32'd0);
      wait_tick(k);
      chk("tick_period", 32'(k), 32'd3);
      step();
      wait_tick(k);
      step();
      chk("after_3_ticks", 32'(counter_out), 32'(mmss(0, 3)));

      // ---- up wrap and terminal ----
      $display("phase: up wrap");
      do_load(6'd58, 6'd58);
      chk("load_idle", 32'(running), 32'd0);
      chk("load_value", 32'(counter_out), 32'(mmss(58, 58)));
      pulse_start(1'b0);
      ndone = 0;
      for (int i = 1; i <= 61; i++) begin
         wait_tick(k);
         if (done) ndone++;
         step();
         if (done) ndone++;
         if (i == 1)  chk("up_t1", 32'(counter_out), 32'(mmss(58, 59)));
         if (i == 2)  chk("up_t2", 32'(counter_out), 32'(mmss(59, 0)));
         if (i == 60) chk("up_t60", 32'(counter_out), 32'(mmss(59, 58)));
         if (i == 60) chk("up_t60_nodone", 32'(done), 32'd0);
      end
      chk("up_final", 32'(counter_out), 32'(mmss(59, 59)));
      chk("up_done_pulse", 32'(done), 32'd1);
      chk("up_stopped", 32'(running), 32'd0);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (done) ndone++;
         if (tick) bad++;
         if (counter_out != mmss(59, 59)) bad++;
      end
      chk("up_done_once", 32'(ndone), 32'd1);
      chk("up_hold", 32'(bad), 32'd0);

      // ---- countdown ----
      $display("phase: countdown");
      do_load(6'd1, 6'd0);
      pulse_start(1'b1);
      for (int i = 1; i <= 60; i++) begin
         wait_tick(k);
         step();
         if (i == 1)  chk("dn_t1", 32'(counter_out), 32'(mmss(0, 59)));
         if (i == 59) chk("dn_t59", 32'(counter_out), 32'(mmss(0, 1)));
         if (i == 59) chk("dn_t59_nodone", 32'(done), 32'd0);
      end
      chk("dn_zero", 32'(counter_out), 32'(mmss(0, 0)));
      chk("dn_done", 32'(done), 32'd1);
      chk("dn_stopped", 32'(running), 32'd0);
      step();
      pulse_start(1'b1);
      chk("dn_start_ignored", 32'(running), 32'd0);
      chk("dn_start_nodone", 32'(done), 32'd0);
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (tick || done || running) bad++;
      end
      chk("dn_done_quiet", 32'(bad), 32'd0);

      // ---- pause / resume keeps the partial prescale ----
      $display("phase: pause resume");
      pulse_clear();
      pulse_start(1'b0);
      step();
      pulse_stop();
      chk("pause_running", 32'(running), 32'd0);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (tick) bad++;
         if (counter_out != mmss(0, 0)) bad++;
      end
      chk("pause_frozen", 32'(bad), 32'd0);
      pulse_start(1'b1);
      chk("resume_running", 32'(running), 32'd1);
      wait_tick(k);
      chk("resume_tick_lat", 32'(k), 32'd1);
      step();
      chk("resume_up_kept", 32'(counter_out), 32'(mmss(0, 1)));

      // ---- priority and clamp ----
      $display("phase: priority clamp");
      load_min = 6'd12;
      load_sec = 6'd12;
      clear = 1'b1;
      load = 1'b1;
      start = 1'b1;
      step();
      clear = 1'b0;
      load = 1'b0;
      start = 1'b0;
      chk("prio_clear_count", 32'(counter_out), 32'(mmss(0, 0)));
      chk("prio_clear_idle", 32'(running), 32'd0);
      load_min = 6'd5;
      load_sec = 6'd5;
      load = 1'b1;
      start = 1'b1;
      step();
      load = 1'b0;
      start = 1'b0;
      chk("prio_load_count", 32'(counter_out), 32'(mmss(5, 5)));
      chk("prio_load_idle", 32'(running), 32'd0);
      stop = 1'b1;
      start = 1'b1;
      step();
      stop = 1'b0;
      start = 1'b0;
      chk("prio_stop_start", 32'(running), 32'd0);
      do_load(6'd63, 6'd61);
      chk("clamp", 32'(counter_out), 32'(mmss(59, 59)));
      pulse_clear();
      pulse_start(1'b1);
      chk("imm_done", 32'(done), 32'd1);
      chk("imm_notrun", 32'(running), 32'd0);
      chk("imm_notick", 32'(tick), 32'd0);
      step();
      chk("imm_done_once", 32'(done), 32'd0);

      // ---- lap ----
      $display("phase: lap");
      pulse_clear();
      pulse_start(1'b0);
      run_ticks(5);
      chk("lap_at5", 32'(counter_out), 32'(mmss(0, 5)));
      pulse_lap();
`ifdef MMSS_COUNTER_LAP_EN
      run_ticks(4);
      chk("lap_frozen", 32'(counter_out), 32'(mmss(0, 5)));
      pulse_lap();
      chk("lap_release", 32'(counter_out), 32'(mmss(0, 9)));
`else
      run_ticks(1);
      chk("lap_ignored", 32'(counter_out), 32'(mmss(0, 6)));
`endif

      // ---- asynchronous reset mid-run ----
      $display("phase: async reset");
      do_load(6'd12, 6'd32);
      pulse_start(1'b0);
      run_ticks(2);
      chk("pre_reset", 32'(counter_out), 32'(mmss(12, 34)));
      step();
      #1 nrst = 1'b0;
      #1;
      chk("areset_count", 32'(counter_out), 32'd0);
      chk("areset_running", 32'(running), 32'd0);
      step();
      nrst = 1'b1;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
